// File: rtl/la_capture_buffer.sv
// Logic-analyzer acquisition: synchronizes probes, samples them at a switch-selected rate into a
// circular trace with a debounced freeze toggle; read data 1 cycle after rd_addr, no backpressure.
module la_capture_buffer #(
   parameter int CH       = 4,
   parameter int DEPTH    = 96,
   parameter int AW       = 7,
   parameter int DIV_SLOW = 100000,
   parameter int DIV_FAST = 1000,
   parameter int DEB      = 1000000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] logic_in_external,
   input  logic          speed_switch,
   input  logic          freeze_button,
   input  logic [AW-1:0] rd_addr,
   output logic [CH-1:0] rd_data,
   output logic [AW-1:0] sample_count,
   output logic          frozen,
   output logic          trace_updated
);

   localparam int MW   = $clog2(DEPTH);
   localparam int DMAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
   localparam int DW   = $clog2(DMAX);
   localparam int BW   = $clog2(DEB);

   typedef enum logic {CAPTURE, HOLD} state_t;

   logic [CH-1:0] probe_s1, probe_s2;
   logic          spd_s1, spd_s2, spd_prev;
   logic          btn_s1, btn_s2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         probe_s1 <= '0;
         probe_s2 <= '0;
         spd_s1   <= 1'b0;
         spd_s2   <= 1'b0;
         btn_s1   <= 1'b0;
         btn_s2   <= 1'b0;
      end else begin
         probe_s1 <= logic_in_external;
         probe_s2 <= probe_s1;
         spd_s1   <= speed_switch;
         spd_s2   <= spd_s1;
         btn_s1   <= freeze_button;
         btn_s2   <= btn_s1;
      end
   end

   // Rate generator: a change of the synced switch restarts the period without ticking.
   logic [DW-1:0] div_cnt, div_last;
   logic          spd_chg, tick;

   assign div_last = spd_s2 ? DW'(DIV_FAST - 1) : DW'(DIV_SLOW - 1);
   assign spd_chg  = spd_s2 ^ spd_prev;
   assign tick     = !spd_chg && (div_cnt == div_last);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         spd_prev <= 1'b0;
         div_cnt  <= '0;
      end else begin
         spd_prev <= spd_s2;
         if (spd_chg || tick) div_cnt <= '0;
         else                 div_cnt <= div_cnt + 1'b1;
      end
   end

   logic [BW-1:0] deb_cnt;
   logic          btn_deb, btn_deb_q, toggle;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb_cnt   <= '0;
         btn_deb   <= 1'b0;
         btn_deb_q <= 1'b0;
      end else begin
         btn_deb_q <= btn_deb;
         if (btn_s2 == btn_deb) begin
            deb_cnt <= '0;
         end else if (deb_cnt == BW'(DEB - 1)) begin
            btn_deb <= btn_s2;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   assign toggle = btn_deb & ~btn_deb_q;

   state_t state, state_nxt;
   logic   wr_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= CAPTURE;
      else      state <= state_nxt;
   end

   // A freeze toggle always beats a coincident tick, in either direction.
   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      case (state)
         CAPTURE: begin
            if (toggle) state_nxt = HOLD;
            else        wr_en     = tick;
         end
         HOLD: begin
            if (toggle) state_nxt = CAPTURE;
         end
         default: state_nxt = CAPTURE;
      endcase
   end

   assign frozen = (state == HOLD);

   logic [MW-1:0] wr_ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr        <= '0;
         sample_count  <= '0;
         trace_updated <= 1'b0;
      end else begin
         trace_updated <= wr_en | toggle;
         if (wr_en) begin
            wr_ptr <= (wr_ptr == MW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (sample_count != AW'(DEPTH)) sample_count <= sample_count + 1'b1;
         end
      end
   end

   // Trace storage is deliberately not reset; sample_count alone says what is valid.
   logic [CH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= probe_s2;
   end

   logic [AW:0]   rd_sum;
   logic [MW-1:0] rd_phys;
   logic          full, rd_valid;

   assign full     = (sample_count == AW'(DEPTH));
   assign rd_sum   = (AW+1)'(wr_ptr) + (AW+1)'(rd_addr);
   assign rd_valid = (rd_addr < sample_count);
   // Once wrapped, the oldest sample sits at wr_ptr; one subtract folds the sum back into range.
   assign rd_phys  = !full ? MW'(rd_addr) :
                     (rd_sum >= (AW+1)'(DEPTH)) ? MW'(rd_sum - (AW+1)'(DEPTH)) : MW'(rd_sum);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_data <= '0;
      else      rd_data <= rd_valid ? mem[rd_phys] : '0;
   end

endmodule
